// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES-bit CLA slice per stage,
// with operand skew and result deskew registers so every slice of an operation exits together.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             en,
    input  logic             vin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             vout,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int W  = WIDTH / STAGES;
    localparam int NG = (W + 3) / 4;

    // Two-level lookahead: 4-bit group G/P, then flattened group carries and in-group carries.
    function automatic logic [W:0] cla_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic cin);
        logic [W-1:0]  g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          t;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 4 * j; (i < 4 * j + 4) && (i < W); i++) begin
                gg[j] = g[i] | (p[i] & gg[j]);
                gp[j] = gp[j] & p[i];
            end
        end
        gc[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            gc[j] = cin;
            for (int i = 0; i < j; i++) gc[j] = gc[j] & gp[i];
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int i = 0; i < W; i++) begin
            c[i] = gc[i / 4];
            for (int m = 4 * (i / 4); m < i; m++) c[i] = c[i] & p[m];
            for (int m = 4 * (i / 4); m < i; m++) begin
                t = g[m];
                for (int n = m + 1; n < i; n++) t = t & p[n];
                c[i] = c[i] | t;
            end
        end
        return {gc[NG], p ^ c};
    endfunction

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff = b ^ {WIDTH{sub}};
    assign c0    = ci ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int DONE = (k + 1) * W;
        logic [W-1:0]    a_sl, b_sl;
        logic            c_sl, vld_sl;
        logic [W:0]      r_sl;
        logic [DONE-1:0] sum_sl;

        if (k == 0) begin : src
            assign a_sl   = a[W-1:0];
            assign b_sl   = b_eff[W-1:0];
            assign c_sl   = c0;
            assign vld_sl = vin;
            assign sum_sl = r_sl[W-1:0];
        end else begin : src
            assign a_sl   = stg[k-1].pipe.a_skew_p[W-1:0];
            assign b_sl   = stg[k-1].pipe.b_skew_p[W-1:0];
            assign c_sl   = stg[k-1].pipe.c_p;
            assign vld_sl = stg[k-1].pipe.vld_p;
            assign sum_sl = {r_sl[W-1:0], stg[k-1].pipe.sum_dsk_p};
        end

        assign r_sl = cla_add(a_sl, b_sl, c_sl);

        if (k < STAGES - 1) begin : pipe
            // ---- stage k -> k+1 boundary: slice carry, valid, unconsumed operands, finished sum
            localparam int REM = WIDTH - DONE;
            logic [REM-1:0]  a_skew_p, b_skew_p, a_nxt, b_nxt;
            logic [DONE-1:0] sum_dsk_p;
            logic            c_p, vld_p;

            if (k == 0) begin : fwd
                assign a_nxt = a[WIDTH-1:W];
                assign b_nxt = b_eff[WIDTH-1:W];
            end else begin : fwd
                assign a_nxt = stg[k-1].pipe.a_skew_p[WIDTH-k*W-1:W];
                assign b_nxt = stg[k-1].pipe.b_skew_p[WIDTH-k*W-1:W];
            end

            always_ff @(posedge clk) begin
                if (!clrn) begin
                    c_p   <= 1'b0;
                    vld_p <= 1'b0;
                end else if (en) begin
                    c_p   <= r_sl[W];
                    vld_p <= vld_sl;
                end
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    a_skew_p  <= a_nxt;
                    b_skew_p  <= b_nxt;
                    sum_dsk_p <= sum_sl;
                end
            end
        end else begin : last
            // ---- final stage: outputs only move when a valid result arrives
            always_ff @(posedge clk) begin
                if (!clrn) begin
                    vout <= 1'b0;
                    s    <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                    zero <= 1'b1;
                end else if (en) begin
                    vout <= vld_sl;
                    if (vld_sl) begin
                        s    <= sum_sl;
                        cout <= r_sl[W];
                        // a^b^s at the MSB recovers the carry into it
                        ovf  <= a_sl[W-1] ^ b_sl[W-1] ^ r_sl[W-1] ^ r_sl[W];
                        zero <= (sum_sl == '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: the same stimulus drives STAGES = 1, 2, 4 and 8 instances; each has
// its own expected-result queue, latency check and output-hold checks.
module tb_pipelined_cla_addsub;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cap;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn, en, vin, ci, sub;
    logic [31:0] a, b;

    logic        vout_w [4];
    logic [31:0] s_w    [4];
    logic        cout_w [4];
    logic        ovf_w  [4];
    logic        zero_w [4];

    exp_t        sbq  [4][$];
    logic [34:0] held [4];
    logic [35:0] prev [4];
    int          n_cmp = 0;
    int          n_err = 0;
    int          adv   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : duts
        pipelined_cla_addsub #(.WIDTH(32), .STAGES(1 << g)) u_dut (
            .clk (clk),
            .clrn(clrn),
            .en  (en),
            .vin (vin),
            .a   (a),
            .b   (b),
            .ci  (ci),
            .sub (sub),
            .vout(vout_w[g]),
            .s   (s_w[g]),
            .cout(cout_w[g]),
            .ovf (ovf_w[g]),
            .zero(zero_w[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {s, cout, ovf, zero}, overflow from the operand/result sign rule
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic m);
        logic [31:0] ye;
        logic [32:0] t;
        logic        o;
        ye = m ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {32'h0, c ^ m};
        o  = (x[31] == ye[31]) && (t[31] != x[31]);
        return {t[31:0], t[32], o, (t[31:0] == 32'h0)};
    endfunction

    always @(negedge clk) begin
        logic [35:0] obs;
        exp_t        e;
        if (en) adv++;
        for (int i = 0; i < 4; i++) begin
            obs = {vout_w[i], s_w[i], cout_w[i], ovf_w[i], zero_w[i]};
            if (!clrn) begin
                check($sformatf("reset_S%0d", 1 << i), 64'(obs), {28'h0, 1'b0, 32'h0, 3'b001});
                held[i] = 35'h1;
            end else if (!en) begin
                check($sformatf("stall_frozen_S%0d", 1 << i), 64'(obs), 64'(prev[i]));
            end else if (vout_w[i]) begin
                if (sbq[i].size() == 0) begin
                    check($sformatf("unexpected_vout_S%0d", 1 << i), 64'(vout_w[i]), 64'(0));
                end else begin
                    e = sbq[i].pop_front();
                    check($sformatf("result_S%0d", 1 << i), 64'(obs[34:0]),
                          64'({e.s, e.cout, e.ovf, e.zero}));
                    check($sformatf("latency_S%0d", 1 << i), 64'(adv),
                          64'(e.cap + (1 << i) - 1));
                    held[i] = obs[34:0];
                end
            end else begin
                check($sformatf("idle_hold_S%0d", 1 << i), 64'(obs[34:0]), 64'(held[i]));
            end
            prev[i] = obs;
        end
    end

    task automatic issue(input logic c_rst_n, input logic c_en, input logic v,
                         input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tci, input logic tsub, input logic [34:0] ex);
        exp_t e;
        @(negedge clk);
        #1;
        clrn = c_rst_n;
        en   = c_en;
        vin  = v;
        a    = ta;
        b    = tb_v;
        ci   = tci;
        sub  = tsub;
        if (!c_rst_n) begin
            for (int i = 0; i < 4; i++) sbq[i].delete();
        end else if (v && c_en) begin
            e.s    = ex[34:3];
            e.cout = ex[2];
            e.ovf  = ex[1];
            e.zero = ex[0];
            e.cap  = adv + 1;
            for (int i = 0; i < 4; i++) sbq[i].push_back(e);
        end
    endtask

    task automatic op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                      input logic tsub);
        issue(1'b1, 1'b1, 1'b1, ta, tb_v, tci, tsub, model(ta, tb_v, tci, tsub));
    endtask

    task automatic op_exp(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci,
                          input logic tsub, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez);
        issue(1'b1, 1'b1, 1'b1, ta, tb_v, tci, tsub, {es, ec, eo, ez});
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 35'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs, rv, re;
        int          pending;
        clrn = 1'b0;
        en   = 1'b1;
        vin  = 1'b0;
        a    = 32'h0;
        b    = 32'h0;
        ci   = 1'b0;
        sub  = 1'b0;
        for (int i = 0; i < 4; i++) prev[i] = '0;
        for (int i = 0; i < 4; i++) held[i] = 35'h1;
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 35'h0);

        // directed vectors, first one accepted on the first edge out of reset
        op_exp(32'h7777_7777, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7777_7776, 1'b1, 1'b0, 1'b0);
        op_exp(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        op_exp(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        op_exp(32'hCCCC_CCCC, 32'hCCCC_CCCC, 1'b0, 1'b0, 32'h9999_9998, 1'b1, 1'b0, 1'b0);
        op_exp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op_exp(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op_exp(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        op_exp(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        nop(10);

        // stall with two operations in flight; operands offered during the stall are ignored
        op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            issue(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 35'h0);
        nop(10);

        // flush three in-flight operations, then accept immediately after reset
        op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        op(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        op(32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1);
        issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 35'h0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        nop(10);

        for (int n = 0; n < 400; n++) begin
            ra = pick();
            rb = pick();
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 149) == 0)
                issue(1'b0, 1'b1, rv, ra, rb, rc, rs, 35'h0);
            else
                issue(1'b1, re, rv, ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        pending = 0;
        for (int i = 0; i < 4; i++) pending += sbq[i].size();
        for (int t = 0; (t < 40) && (pending != 0); t++) begin
            nop(1);
            pending = 0;
            for (int i = 0; i < 4; i++) pending += sbq[i].size();
        end
        check("drain_outstanding", 64'(pending), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values 8 to 64.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, with slice width W = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; every register updates on the rising edge only.
REQ-004 clrn  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-005 en  input  1  pipeline advance enable; 0 = hold every register.
REQ-006 vin  input  1  operands on a, b, ci, sub are valid this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in in add mode, borrow-in in subtract mode.
REQ-010 sub  input  1  mode select; 0 = add, 1 = subtract.
REQ-011 vout  output  1  s and the flags hold a valid result.
REQ-012 s  output  WIDTH  sum or difference.
REQ-013 cout  output  1  carry-out from the MSB; in subtract mode, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  s is all zeros.

Function
REQ-016 Effective operand b' = b XOR {WIDTH{sub}}; effective carry-in c0 = ci XOR sub.
REQ-017 Result {cout, s} = a + b' + c0, computed modulo 2^(WIDTH+1).
- Mode consequences: sub=0 gives a+b+ci; sub=1, ci=0 gives a-b; sub=1, ci=1 gives a-b-1.
REQ-018 Stage k (0..STAGES-1) SHALL add slice k of a and b' with a W-bit carry-lookahead adder.
- Lookahead structure: 4-bit generate/propagate groups, with group lookahead above that; no ripple across more than 4 bits.
- Carry into slice k is the carry registered out of stage k-1; c0 for slice 0.
REQ-019 Operand slices not yet consumed SHALL travel through skew registers alongside the pipeline; completed result slices SHALL travel through deskew registers alongside it.
- All slices of one operation emerge on s in the same cycle.
REQ-020 Latency: with en=1 throughout, an operation captured at rising edge N SHALL appear on s, cout, ovf, zero and vout after edge N+STAGES-1. Latency is therefore STAGES cycles, where STAGES=1 means one registered cycle.
REQ-021 Throughput SHALL be one operation per cycle while en=1; back-to-back operations SHALL NOT interact.
REQ-022 vin SHALL propagate through a STAGES-deep valid shift register that is aligned with the data.
REQ-023 When vout=0, s, cout, ovf and zero SHALL hold their previous values and carry no meaning.
REQ-024 ovf SHALL equal (carry into bit WIDTH-1) XOR cout, registered in the final stage and aligned with s.
REQ-025 zero SHALL be 1 exactly when the final s equals 0, registered and aligned with s.
REQ-026 When en=0 at an edge, all data, carry, skew, deskew and valid registers SHALL hold their values; vin and operands at that edge SHALL be ignored.
REQ-027 When en returns to 1, the pipeline SHALL resume with no loss or duplication of operations.
REQ-028 Carry-out wrap-around is not an error: the lower WIDTH bits appear on s and the extra bit appears on cout.

Reset
REQ-029 When clrn=0 at a rising edge, all valid bits, vout, s, cout, ovf and all internal carry registers SHALL become 0, and zero SHALL become 1.
REQ-030 Reset SHALL take priority over en.
REQ-031 An assertion of clrn while operations are in flight SHALL discard them; none of them SHALL emerge after reset.
REQ-032 On the first edge with clrn=1, vin SHALL be accepted normally.

Verification
REQ-033 The bench SHALL cover the following directed scenarios with WIDTH=32 and STAGES=4 (results emerge 4 cycles after capture):
- V1: sub=0: a=77777777h, b=FFFFFFFFh, ci=0 -> s=77777776h, cout=1, ovf=0, zero=0.
- V2: back-to-back operations on consecutive edges, both sub=0:
  - aaaaaaaah+55555555h, ci=0 -> s=FFFFFFFFh, cout=0.
  - the same operands with ci=1 -> s=00000000h, cout=1, zero=1, emerging on consecutive cycles.
- V3: sub=0: cccccccch+cccccccch, ci=0 -> s=99999998h, cout=1, ovf=0.
  - 7FFFFFFFh+00000001h -> s=80000000h, ovf=1.
- V4: sub=1, ci=0:
  - a=5, b=7 -> s=FFFFFFFEh, cout=0.
  - a=80000000h, b=1 -> s=7FFFFFFFh, ovf=1, cout=1.
- V5: en=0 held for 3 cycles while 2 operations are in flight -> outputs frozen during the stall; both results emerge in order once en=1, with total latency 4 plus 3 cycles.
- V6: clrn=0 for one edge with 3 operations in flight -> vout=0 and s=0 on the next cycle; none of the flushed results ever appears.
- Random sweep across STAGES in {1,2,4,8} against a reference model, with a checker on latency, flags and vout alignment.
